// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-at-a-time requests to
// instruction memory and buffers returned {pc, instr} pairs in a 2-entry queue.
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stallF,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] PCounterF,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] PCPlus4F,
   output logic                  validF
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_DROP
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] head_pc_q, head_pc_d;
   logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
   logic [DATA_WIDTH-1:0] tail_pc_q, tail_pc_d;
   logic [DATA_WIDTH-1:0] tail_instr_q, tail_instr_d;

   logic       not_empty;
   logic       pop;
   logic       push;
   logic [2:0] occ_next;
   logic [1:0] fill_idx;
   logic       req;
   logic       grant;

   // Occupancy counts the response landing this cycle, so a request is only
   // issued when its eventual response is guaranteed a free slot.
   always_comb begin
      not_empty = (count_q != 2'd0);
      pop       = not_empty && !stallF;
      push      = (state_q == ST_WAIT) && imem_rvalid && !PCSrcE;
      occ_next  = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
      fill_idx  = count_q - {1'b0, pop};
      req       = rst_n && !PCSrcE
                  && ((state_q == ST_RUN) || ((state_q == ST_WAIT) && imem_rvalid))
                  && (occ_next < 3'd2);
      grant     = req && imem_gnt;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (grant) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (PCSrcE) begin
               state_d = imem_rvalid ? ST_RUN : ST_DROP;
            end else if (imem_rvalid) begin
               state_d = grant ? ST_WAIT : ST_RUN;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      if (PCSrcE) begin
         fetch_pc_d = PCTargetE;
      end else if (grant) begin
         fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
         pend_pc_d  = fetch_pc_q;
      end
   end

   // Head is always slot 0; a pop shifts the tail forward before the new
   // entry is written into the first free slot.
   always_comb begin
      count_d      = count_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      tail_pc_d    = tail_pc_q;
      tail_instr_d = tail_instr_q;
      if (PCSrcE) begin
         count_d = 2'd0;
      end else begin
         count_d = occ_next[1:0];
         if (pop) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
         end
         if (push) begin
            if (fill_idx == 2'd0) begin
               head_pc_d    = pend_pc_q;
               head_instr_d = imem_rdata;
            end else begin
               tail_pc_d    = pend_pc_q;
               tail_instr_d = imem_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         fetch_pc_q   <= RESET_PC;
         pend_pc_q    <= '0;
         count_q      <= 2'd0;
         head_pc_q    <= '0;
         head_instr_q <= '0;
         tail_pc_q    <= '0;
         tail_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pend_pc_q    <= pend_pc_d;
         count_q      <= count_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         tail_pc_q    <= tail_pc_d;
         tail_instr_q <= tail_instr_d;
      end
   end

   always_comb begin
      imem_req  = req;
      imem_addr = fetch_pc_q;
      validF    = not_empty;
      PCounterF = not_empty ? head_pc_q : '0;
      instr     = not_empty ? head_instr_q : '0;
      PCPlus4F  = not_empty ? (head_pc_q + DATA_WIDTH'(4)) : '0;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-randomised memory model feeds the
// DUT, and a monitor checks every presented head against the expected PC stream.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        stallF;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PCounterF;
   logic [31:0] instr;
   logic [31:0] PCPlus4F;
   logic        validF;

   fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stallF(stallF), .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PCounterF(PCounterF), .instr(instr), .PCPlus4F(PCPlus4F), .validF(validF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } mem_t;

   mem_t        memq[$];
   logic [31:0] exp_pc[$];
   int          cycle = 0;
   int          cur_lat_min = 1;
   int          cur_lat_max = 1;
   int          n_checks = 0;
   int          n_pass = 0;
   int          pops_total = 0;
   int          phase = 0;
   int          first_grant = -1;
   int          first_valid = -1;
   int          valid_cnt = 0;
   bit          seen_wrap = 0;
   logic [31:0] m_pc = RST_PC;
   logic        p_req = 0, p_gnt = 0, p_redir = 0;
   logic [31:0] p_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = $urandom;
      t[1:0] = 2'b00;
      if ($urandom_range(7, 0) == 0) t[31:5] = '1;
      return t;
   endfunction

   task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cycle);
   endtask

   // One bench cycle: responses come from the memory queue, the rest is random
   // or forced by redir_mode (1: while outstanding, 2: with rvalid, 3: now).
   task automatic apply_stimulus(input int gnt_pct, input int stall_pct, input int redir_pct,
                                 input int lat_min, input int lat_max, input int redir_mode,
                                 input logic [31:0] target, output bit fired);
      @(posedge clk);
      #1;
      cycle++;
      cur_lat_min = lat_min;
      cur_lat_max = lat_max;
      fired = 1'b0;
      if (rst_n && memq.size() > 0 && memq[0].ready <= cycle) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(memq[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      imem_gnt  = ($urandom_range(99, 0) < gnt_pct);
      stallF    = ($urandom_range(99, 0) < stall_pct);
      PCSrcE    = 1'b0;
      PCTargetE = $urandom;
      if (rst_n) begin
         case (redir_mode)
            0: if ($urandom_range(99, 0) < redir_pct) begin
                  PCSrcE = 1'b1; PCTargetE = rand_target();
               end
            1: if (memq.size() > 0 && !imem_rvalid) begin
                  PCSrcE = 1'b1; PCTargetE = target; fired = 1'b1;
               end
            2: if (imem_rvalid) begin
                  PCSrcE = 1'b1; PCTargetE = target; fired = 1'b1;
               end
            default: begin
               PCSrcE = 1'b1; PCTargetE = target; fired = 1'b1;
            end
         endcase
      end
   endtask

   // Memory model: retire the response shown this cycle, then accept a grant.
   always @(negedge clk) begin
      if (!rst_n) begin
         memq.delete();
      end else begin
         if (imem_rvalid) void'(memq.pop_front());
         if (imem_req && imem_gnt) begin
            check_value("one_outstanding", memq.size(), 0);
            memq.push_back('{addr: imem_addr,
                             ready: cycle + $urandom_range(cur_lat_max, cur_lat_min)});
         end
      end
   end

   // Monitor: expected PCs are queued on each grant, flushed on redirect/reset,
   // and popped whenever the DUT hands its head downstream.
   always @(negedge clk) begin
      if (!rst_n) begin
         check_value("req_in_reset", imem_req, 0);
         check_value("valid_in_reset", validF, 0);
         check_value("pc_in_reset", PCounterF, 0);
         m_pc = RST_PC;
         exp_pc.delete();
         p_req = 0; p_gnt = 0; p_redir = 0;
      end else begin
         check_value("imem_addr", imem_addr, m_pc);
         if (PCSrcE) check_value("req_during_redirect", imem_req, 0);
         if (p_req && !p_gnt && !PCSrcE) begin
            check_value("req_held", imem_req, 1);
            check_value("addr_held", imem_addr, p_addr);
         end
         if (p_redir) check_value("valid_after_redirect", validF, 0);
         if (!validF) begin
            check_value("empty_pc", PCounterF, 0);
            check_value("empty_instr", instr, 0);
            check_value("empty_pcplus4", PCPlus4F, 0);
         end else if (exp_pc.size() == 0) begin
            check_value("head_without_fetch", validF, 0);
         end else begin
            check_value("head_pc", PCounterF, exp_pc[0]);
            check_value("head_instr", instr, mem_word(exp_pc[0]));
            check_value("head_pcplus4", PCPlus4F, exp_pc[0] + 32'd4);
            if (PCounterF == 32'hFFFF_FFFC && PCPlus4F == 32'h0) seen_wrap = 1;
            if (!stallF && !PCSrcE) begin
               void'(exp_pc.pop_front());
               pops_total++;
            end
         end
         if (phase == 1) begin
            if (imem_req && imem_gnt && first_grant < 0) first_grant = cycle;
            if (validF) begin
               valid_cnt++;
               if (first_valid < 0) first_valid = cycle;
            end
         end
         if (PCSrcE) begin
            exp_pc.delete();
            m_pc = PCTargetE;
         end else if (imem_req && imem_gnt) begin
            exp_pc.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
         if (exp_pc.size() > 2) check_value("queue_overflow", exp_pc.size(), 2);
         p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr; p_redir = PCSrcE;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit fired;
      bit done;
      int gp, sp, rp, lm;
      rst_n = 1'b0; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (3) apply_stimulus(0, 0, 0, 1, 1, 0, 32'h0, fired);

      // Streaming from reset: first head two cycles after the first grant.
      phase = 1;
      apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      rst_n = 1'b1;
      repeat (21) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      phase = 0;
      check_value("first_grant_cycle_seen", (first_grant >= 0), 1);
      check_value("first_valid_latency", first_valid - first_grant, 2);
      check_value("stream_valid_cycles", valid_cnt, 20);

      // Stall with streaming memory: queue fills and requests stop.
      repeat (3) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      repeat (4) apply_stimulus(100, 100, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      check_value("stall_full_req", imem_req, 0);
      check_value("stall_full_valid", validF, 1);
      repeat (10) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);

      // Redirect while a slow response is outstanding.
      done = 0;
      for (int k = 0; k < 30 && !done; k++) begin
         apply_stimulus(100, 0, 0, 3, 3, 1, 32'h0000_0200, fired);
         done = fired;
      end
      check_value("late_redirect_fired", done, 1);
      @(negedge clk); #1;
      check_value("late_redirect_req", imem_req, 0);
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         apply_stimulus(100, 0, 0, 3, 3, 0, 32'h0, fired);
         @(negedge clk); #1;
         done = validF;
      end
      check_value("late_redirect_head", PCounterF, 32'h0000_0200);

      // Redirect in the same cycle as a response.
      repeat (4) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      done = 0;
      for (int k = 0; k < 30 && !done; k++) begin
         apply_stimulus(100, 0, 0, 1, 1, 2, 32'h0000_0300, fired);
         done = fired;
      end
      check_value("rvalid_redirect_fired", done, 1);
      apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      check_value("rvalid_redirect_req", imem_req, 1);
      check_value("rvalid_redirect_addr", imem_addr, 32'h0000_0300);

      // Grant withheld for five cycles.
      repeat (4) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      apply_stimulus(0, 0, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      check_value("gnt_low_req", imem_req, 1);
      repeat (4) apply_stimulus(0, 0, 0, 1, 1, 0, 32'h0, fired);
      repeat (6) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);

      // Address wrap at the top of the address space.
      apply_stimulus(100, 0, 0, 1, 1, 3, 32'hFFFF_FFF0, fired);
      repeat (12) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      check_value("wrap_head_seen", seen_wrap, 1);

      // Randomised traffic with a reset in the middle.
      gp = 100; sp = 0; rp = 0; lm = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            gp = $urandom_range(100, 30);
            sp = $urandom_range(50, 0);
            rp = $urandom_range(8, 0);
            lm = $urandom_range(4, 1);
         end
         apply_stimulus(gp, sp, rp, 1, lm, 0, 32'h0, fired);
         if (i == 1500) rst_n = 1'b0;
         if (i == 1502) rst_n = 1'b1;
      end

      repeat (30) apply_stimulus(100, 0, 0, 1, 1, 0, 32'h0, fired);
      @(negedge clk); #1;
      check_value("enough_instructions", (pops_total > 300), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
